// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               d_bit;
    logic               br_nxt;
    logic               load;
`ifdef SERIAL_SUB_OVF_EN
    logic               amsb_q, amsb_d;
    logic               bmsb_q, bmsb_d;
    logic               ovf_q, ovf_d;
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif

        d_bit  = ra_q[0] ^ rb_q[0] ^ br_q;
        br_nxt = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
        load   = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                busy_d = 1'b1;
                ra_d   = ra_q >> 1;
                rb_d   = rb_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // Result MSB is the bit produced on this final edge
                    ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ d_bit);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
            ra_d    = a;
            rb_d    = b;
            res_d   = '0;
            cnt_d   = '0;
            br_d    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_d  = a[WIDTH-1];
            bmsb_d  = b[WIDTH-1];
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int unsigned  n_checks = 0;
    int unsigned  n_err    = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check_eq({tag, "_bout"}, 32'(Bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
    endtask

    // Expects start/a/b already driven for the coming edge; leaves the bench
    // just after the negedge following done, with start set for the DONE edge.
    task automatic finish_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise,
                             input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
        int lat;
        int sd;
        lat = 0;
        @(posedge clk);
        #1;
        check_eq("accept_busy", 32'(busy), 32'd1);
        check_eq("accept_done", 32'(done), 32'd0);
        for (int k = 1; k <= int'(W) + 3; k++) begin
            @(negedge clk);
            if (noise) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            check_eq("shift_busy", 32'(busy), 32'd1);
            check_held("shift_hold");
        end
        check_eq("latency", 32'(lat), 32'(W));
        check_eq("done_busy", 32'(busy), 32'd0);
        exp_diff = W'(av - bv);
        exp_bout = (av < bv);
        sd       = int'($signed(av)) - int'($signed(bv));
        exp_ovf  = (sd > 127) || (sd < -128);
        check_held("result");
        @(negedge clk);
        if (chain) begin
            start = 1'b1;
            a     = na;
            b     = nb;
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
        launch(av, bv);
        finish_op(av, bv, noise, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_eq("post_done", 32'(done), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ca, cb, nxa, nxb;
        bit           pend;
        bit           ch;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_held("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_one(8'h05, 8'h03, 1'b0);

        launch(8'h03, 8'h05);
        finish_op(8'h03, 8'h05, 1'b0, 1'b1, 8'h00, 8'h01);
        finish_op(8'h00, 8'h01, 1'b0, 1'b0, '0, '0);

        run_one(8'hFF, 8'hFF, 1'b1);

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_done", 32'(done), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_held("idle");
        end

        // Abort mid-operation with an asynchronous reset
        launch(8'h40, 8'h10);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_held("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check_eq("after_abort_done", 32'(done), 32'd0);
            check_eq("after_abort_busy", 32'(busy), 32'd0);
        end

        run_one(8'h80, 8'h01, 1'b0);
        run_one(8'h7F, 8'hFF, 1'b0);
        run_one(8'h10, 8'h01, 1'b0);
        run_one(8'h00, 8'h00, 1'b0);

        pend = 1'b0;
        ca   = '0;
        cb   = '0;
        for (int i = 0; i < 30; i++) begin
            if (!pend) begin
                ca = W'($urandom);
                cb = W'($urandom);
                launch(ca, cb);
            end
            nxa = W'($urandom);
            nxb = W'($urandom);
            ch  = (i < 29) && (($urandom % 3) == 0);
            finish_op(ca, cb, 1'($urandom), ch, nxa, nxb);
            pend = ch;
            if (ch) begin
                ca = nxa;
                cb = nxb;
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                    check_eq("rand_idle_done", 32'(done), 32'd0);
                    check_held("rand_idle");
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b one bit per clock with a registered borrow. It is the inverse-operation counterpart to the 1-bit half-adder arithmetic block.
- Sits beside the adder primitives in the arithmetic library. It serves area-constrained paths that accept multi-cycle latency.
- A start/busy/done handshake brackets each operation. The result is held until the next completion.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on clk rising edge
- a  input  WIDTH  minuend; sampled only when start is accepted
- b  input  WIDTH  subtrahend; sampled only when start is accepted
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result a - b modulo 2^WIDTH; held between completions
- Bout  output  1  final borrow; 1 iff a < b unsigned; held with diff

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state:
  - state=IDLE, busy=0, done=0, diff=0, Bout=0.
  - Internal shift registers, bit counter and borrow flop cleared.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE -> SHIFT when start=1 at an edge. On that edge:
  - a and b load into shift registers ra and rb.
  - borrow flop br=0, counter=0.
- SHIFT, each edge processes one bit, LSB first:
  - d = ra[0] ^ rb[0] ^ br
  - br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)
  - ra and rb shift right by 1.
  - d shifts into the MSB of the working result register; prior contents shift right.
  - counter increments.
- SHIFT -> DONE on the edge that processes bit WIDTH-1. On that same edge:
  - The complete working result is copied to diff.
  - br_next is copied to Bout.
- DONE lasts exactly one cycle (done=1).
  - start=1 at that edge: go to SHIFT and load new operands (back-to-back supported).
  - Otherwise: go to IDLE.
- Latency: start sampled at edge 0 -> busy high from edge 0 to edge WIDTH -> done high for the single cycle following edge WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no reload, no effect on the result.
- a and b may change freely except at the accepting edge.
- diff and Bout change only on SHIFT->DONE transitions or on reset. They are stable in IDLE and during subsequent SHIFT.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; Bout is the borrow out of bit WIDTH-1.
  - Wrap-around example: 0 - 1 = all-ones, Bout=1.
- Reset mid-operation aborts the operation with no done pulse. The first start after reset deasserts behaves as from power-up.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside diff and Bout.
  - ovf = signed two's-complement overflow = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]), computed from the original operand MSBs captured at load.
  - ovf resets to 0 and is held with diff.
- When undefined: the port and all associated logic are absent. Other behaviour is identical.

Test Plan:
- WIDTH=8, reset released, start with a=0x05, b=0x03 -> busy high 8 cycles; done pulses once in the cycle after the 8th SHIFT edge; diff=0x02, Bout=0.
- a=0x03, b=0x05 -> diff=0xFE, Bout=1. Then a=0x00, b=0x01 issued back-to-back with start held during DONE -> second done 9 cycles after the first; diff=0xFF, Bout=1.
- a=0xFF, b=0xFF -> diff=0x00, Bout=0. start toggled and a/b changed during busy -> result unchanged, no extra done.
- Start a=0x40, b=0x10; assert rst_n=0 after 4 SHIFT cycles -> busy, done, diff, Bout go to 0 immediately with no clock; after release, no done until a new start.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, Bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, Bout=1, ovf=1; a=0x10, b=0x01 -> ovf=0.
- Idle hold: after a completion, 20 idle cycles with start=0 -> diff/Bout stable, done=0, busy=0.
